mmio_frame_latch: RTL

MMIO_FRAME_LATCH -- requirements
Module: mmio_frame_latch

---
 rtl/mmio_frame_latch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mmio_frame_latch.sv
// Double-buffered frame state written over MMIO: commands update a shadow set, and COMMIT swaps it into the active set at vsync.
// Optional MMIO_FRAME_STATS_EN adds a 16-bit wrapping swap counter output (commit_count).
module mmio_frame_latch #(
  parameter int NUM_PIPES = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [31:0]               mmio_out,
  input  logic                      mmio_we,
  input  logic                      vsync,
  output logic [Y_W-1:0]            bird_y,
  output logic [NUM_PIPES*X_W-1:0]  pipe_x,
  output logic [NUM_PIPES*Y_W-1:0]  pipe_gap,
  output logic [15:0]               score,
  output logic                      commit_pending,
  output logic                      frame_ready,
  output logic                      cmd_err
`ifdef MMIO_FRAME_STATS_EN
  ,
  output logic [15:0]               commit_count
`endif
);

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_SET_BIRD  = 4'd1;
  localparam logic [3:0] OP_SET_PIPE  = 4'd2;
  localparam logic [3:0] OP_SET_SCORE = 4'd3;
  localparam logic [3:0] OP_COMMIT    = 4'd4;

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t st, st_nxt;

  logic [3:0] opcode_p0;
  logic [1:0] pipe_idx_p0;
  logic       wr_bird_p0, wr_pipe_p0, wr_score_p0, commit_req_p0, bad_cmd_p0;
  logic       swap;

  logic [Y_W-1:0]           sh_bird_y;
  logic [NUM_PIPES*X_W-1:0] sh_pipe_x, sh_pipe_x_nxt;
  logic [NUM_PIPES*Y_W-1:0] sh_pipe_gap, sh_pipe_gap_nxt;
  logic [15:0]              sh_score;

  // Payload bits outside the decoded fields are intentionally don't-care.
  logic unused_payload;
  assign unused_payload = ^mmio_out;

  assign opcode_p0   = mmio_out[31:28];
  assign pipe_idx_p0 = mmio_out[25:24];

  // Stage p0: command decode
  always_comb begin
    wr_bird_p0    = 1'b0;
    wr_pipe_p0    = 1'b0;
    wr_score_p0   = 1'b0;
    commit_req_p0 = 1'b0;
    bad_cmd_p0    = 1'b0;
    if (mmio_we) begin
      case (opcode_p0)
        OP_NOP:       begin end
        OP_SET_BIRD:  wr_bird_p0 = 1'b1;
        OP_SET_PIPE: begin
          if (int'(pipe_idx_p0) < NUM_PIPES) wr_pipe_p0 = 1'b1;
          else                               bad_cmd_p0 = 1'b1;
        end
        OP_SET_SCORE: wr_score_p0 = 1'b1;
        OP_COMMIT:    commit_req_p0 = 1'b1;
        default:      bad_cmd_p0 = 1'b1;
      endcase
    end
  end

  always_comb begin
    sh_pipe_x_nxt   = sh_pipe_x;
    sh_pipe_gap_nxt = sh_pipe_gap;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (wr_pipe_p0 && (int'(pipe_idx_p0) == i)) begin
        sh_pipe_x_nxt[i*X_W +: X_W]   = mmio_out[10 +: X_W];
        sh_pipe_gap_nxt[i*Y_W +: Y_W] = mmio_out[Y_W-1:0];
      end
    end
  end

  // A COMMIT landing on the swap cycle belongs to the next frame, so it re-arms.
  always_comb begin
    st_nxt = st;
    swap   = 1'b0;
    case (st)
      ST_IDLE:    if (commit_req_p0) st_nxt = ST_PENDING;
      ST_PENDING: begin
        if (vsync) begin
          swap = 1'b1;
          if (!commit_req_p0) st_nxt = ST_IDLE;
        end
      end
      default:    st_nxt = ST_IDLE;
    endcase
  end

  assign commit_pending = (st == ST_PENDING);

  // Stage p1: shadow and active register update
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      frame_ready <= 1'b0;
      cmd_err     <= 1'b0;
      sh_bird_y   <= '0;
      sh_pipe_x   <= '0;
      sh_pipe_gap <= '0;
      sh_score    <= '0;
      bird_y      <= '0;
      pipe_x      <= '0;
      pipe_gap    <= '0;
      score       <= '0;
    end else begin
      st          <= st_nxt;
      frame_ready <= swap;
      if (bad_cmd_p0) cmd_err <= 1'b1;
      if (wr_bird_p0) sh_bird_y <= mmio_out[Y_W-1:0];
      sh_pipe_x   <= sh_pipe_x_nxt;
      sh_pipe_gap <= sh_pipe_gap_nxt;
      if (wr_score_p0) sh_score <= mmio_out[15:0];
      if (swap) begin
        bird_y   <= sh_bird_y;
        pipe_x   <= sh_pipe_x;
        pipe_gap <= sh_pipe_gap;
        score    <= sh_score;
      end
    end
  end

`ifdef MMIO_FRAME_STATS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    commit_count <= '0;
    else if (swap) commit_count <= commit_count + 16'd1;
  end
`endif

endmodule
